// File: rtl/basic_spi_pkg.sv
// -----------------------------------------------------------------------------
// basic_spi_pkg
// Shared constants for the basic SPI slave.
//   SPI_WIDTH    default word length in bits
//   SYNC_STAGES  default depth of each pin synchronizer
//   ST_IDLE      frame not in progress (cs_n high)
//   ST_ACTIVE    frame in progress (cs_n low), miso driven
// -----------------------------------------------------------------------------
package basic_spi_pkg;

  localparam int SPI_WIDTH   = 16;
  localparam int SYNC_STAGES = 2;

  typedef logic state_t;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

endpackage : basic_spi_pkg

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous pin into the clk domain through SYNC_STAGES flops
// and produces single-cycle pulses on its rising and falling edges.
// Ports:
//   clk     system clock
//   rst     synchronous, active-high reset
//   pin_i   asynchronous input pin
//   rise_o  1-clk pulse: synchronized pin went 0 -> 1
//   fall_o  1-clk pulse: synchronized pin went 1 -> 0
// Parameters:
//   SYNC_STAGES  synchronizer depth (must be >= 2)
//   RESET_VAL    idle level of the pin; the chain resets to it so that no
//                spurious edge is reported when reset is released
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge pulses are combinational off the last stage, so the consuming logic
  // acts on the clk edge after the pulse: SYNC_STAGES+1 clk from the pin.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule : spi_sync_edge

// File: rtl/basic_spi_slave.sv
// -----------------------------------------------------------------------------
// basic_spi_slave
// SPI mode 0 (CPOL=0, CPHA=0), MSB-first slave. sclk, cs_n and mosi are
// oversampled in the clk domain. One shift register serves both directions:
// its MSB drives miso while received bits enter at the LSB.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   sclk        SPI clock from master (async, at most clk/8)
//   cs_n        chip select from master (async, active low)
//   mosi        serial data from master (async)
//   miso        serial data to master; shift MSB while active, else 0
//   miso_oe     tri-buffer enable for miso; high only while active
//   data_in     TX word from CPU, captured on we
//   we          1-clk write strobe for data_in
//   data_out    last complete RX word
//   rd          1-clk strobe: CPU consumed data_out
//   rx_valid    data_out holds an unread word
//   done        1-clk pulse when a word completes
//   tx_empty    TX buffer consumed, CPU may write the next word
//   overrun     sticky: a word completed while rx_valid was still set
// -----------------------------------------------------------------------------
module basic_spi_slave #(
  parameter int WIDTH       = basic_spi_pkg::SPI_WIDTH,
  parameter int SYNC_STAGES = basic_spi_pkg::SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] data_in,
  input  logic             we,
  output logic [WIDTH-1:0] data_out,
  input  logic             rd,
  output logic             rx_valid,
  output logic             done,
  output logic             tx_empty,
  output logic             overrun
);

  import basic_spi_pkg::*;

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // cs_n idles high, so its chain resets high.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // mosi only needs its level; it has the same latency as the sclk chain so
  // the bit seen on a detected sclk rise is the one the master set up.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_next
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d = ST_ACTIVE;
      end
    end else begin
      if (cs_rise) begin
        state_d = ST_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             rx_bit_q, rx_bit_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_full_q, tx_full_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             done_q, done_d;

  // Events qualified by state. A cs_rise masks any sclk edge in the same clk
  // so that the frame ends without a last shift or a late completion.
  logic act_evt;
  logic load_word;
  logic word_end;
  logic shift_evt;

  assign act_evt   = (state_q == ST_ACTIVE) && !cs_rise;
  assign load_word = ((state_q == ST_IDLE) && cs_fall) ||
                     (act_evt && sclk_fall && (bit_cnt_q == CNT_FULL));
  assign word_end  = act_evt && sclk_rise && (bit_cnt_q == CNT_LAST);
  assign shift_evt = act_evt && sclk_fall && (bit_cnt_q < CNT_FULL);

  always_comb begin : datapath_next
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_bit_d   = rx_bit_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    data_out_d = data_out_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    done_d     = 1'b0;

    // Start of a word (frame start or back-to-back): the reload reads the
    // buffer as it was before any write landing in this same clk.
    if (load_word) begin
      shift_d   = tx_full_q ? tx_buf_q : '0;
      tx_full_d = 1'b0;
      bit_cnt_d = '0;
    end else if (shift_evt) begin
      shift_d = {shift_q[WIDTH-2:0], rx_bit_q};
    end

    // Sample on the rising edge; the counter saturates at WIDTH until the
    // following falling edge reloads it.
    if (act_evt && sclk_rise) begin
      rx_bit_d = mosi_sync;
      if (bit_cnt_q != CNT_FULL) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // Applied after the reload so a simultaneous write leaves the buffer full.
    if (we) begin
      tx_buf_d  = data_in;
      tx_full_d = 1'b1;
    end

    if (rd) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    // Completion takes priority over rd; a word read in the same clk it is
    // replaced does not count as lost.
    if (word_end) begin
      data_out_d = {shift_q[WIDTH-2:0], mosi_sync};
      done_d     = 1'b1;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_bit_q   <= 1'b0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      data_out_q <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_bit_q   <= rx_bit_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      data_out_q <= data_out_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_outputs
    miso    = 1'b0;
    miso_oe = 1'b0;
    if (state_q == ST_ACTIVE) begin
      miso    = shift_q[WIDTH-1];
      miso_oe = 1'b1;
    end
  end

  assign data_out = data_out_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign done     = done_q;
  assign tx_empty = !tx_full_q;

endmodule : basic_spi_slave

// File: tb/tb_basic_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_basic_spi_slave
// Directed bench for basic_spi_slave: drives the SPI pins as a mode-0 master
// (sclk = clk/8) plus the CPU strobes, and checks outputs against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_basic_spi_slave;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic [W-1:0] data_in;
  logic         we;
  logic [W-1:0] data_out;
  logic         rd;
  logic         rx_valid;
  logic         done;
  logic         tx_empty;
  logic         overrun;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  basic_spi_slave #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out),
    .rd       (rd),
    .rx_valid (rx_valid),
    .done     (done),
    .tx_empty (tx_empty),
    .overrun  (overrun)
  );

  // done is a registered pulse; counting on the falling edge sees each one once.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    clks(8);
  endtask

  task automatic cs_high();
    clks(8);
    cs_n = 1'b1;
    clks(8);
  endtask

  task automatic cpu_write(input logic [W-1:0] d);
    data_in = d;
    we      = 1'b1;
    clks(1);
    we      = 1'b0;
  endtask

  task automatic cpu_read();
    rd = 1'b1;
    clks(1);
    rd = 1'b0;
  endtask

  // Master shifts nbits MSB-first: mosi set while sclk low, miso sampled at
  // the sclk rise. Each sclk phase lasts 4 clk.
  task automatic spi_bits(input logic [W-1:0] tx, input int nbits,
                          output logic [W-1:0] rx);
    rx = '0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      mosi = tx[i];
      clks(4);
      sclk  = 1'b1;
      rx[i] = miso;
      clks(4);
      sclk = 1'b0;
    end
    $display("spi: mosi=%h bits=%0d miso=%h", tx, nbits, rx);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clks(4);
    rst = 1'b0;
    clks(4);
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
    n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_data_out: got %h want 0000", data_out); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_tx_empty: got %b want 1", tx_empty); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_single_word();
    logic [W-1:0] rx;
    cpu_write(16'hA55A);
    n_cmp++; if (tx_empty !== 1'b0) begin n_bad++; $display("FAIL word_tx_empty_after_we: got %b want 0", tx_empty); end
    done_cnt = 0;
    cs_low();
    n_cmp++; if (miso_oe !== 1'b1) begin n_bad++; $display("FAIL word_miso_oe_active: got %b want 1", miso_oe); end
    spi_bits(16'h3C0F, W, rx);
    cs_high();
    n_cmp++; if (rx !== 16'hA55A) begin n_bad++; $display("FAIL word_miso: got %h want a55a", rx); end
    n_cmp++; if (data_out !== 16'h3C0F) begin n_bad++; $display("FAIL word_data_out: got %h want 3c0f", data_out); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL word_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL word_rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL word_tx_empty: got %b want 1", tx_empty); end
    n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL word_miso_oe_idle: got %b want 0", miso_oe); end
    cpu_read();
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL word_rd_rx_valid: got %b want 0", rx_valid); end
  endtask

  task automatic test_no_tx();
    logic [W-1:0] rx;
    cs_low();
    spi_bits(16'hFFFF, W, rx);
    cs_high();
    n_cmp++; if (rx !== 16'h0000) begin n_bad++; $display("FAIL notx_miso: got %h want 0000", rx); end
    n_cmp++; if (data_out !== 16'hFFFF) begin n_bad++; $display("FAIL notx_data_out: got %h want ffff", data_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL notx_overrun: got %b want 0", overrun); end
    cpu_read();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rx1, rx2;
    done_cnt = 0;
    cs_low();
    // The frame start already consumed the empty buffer, so this word is
    // what the second word's reload picks up.
    cpu_write(16'hBEEF);
    n_cmp++; if (tx_empty !== 1'b0) begin n_bad++; $display("FAIL b2b_tx_empty_after_we: got %b want 0", tx_empty); end
    spi_bits(16'h1234, W, rx1);
    spi_bits(16'h5678, W, rx2);
    cs_high();
    n_cmp++; if (rx1 !== 16'h0000) begin n_bad++; $display("FAIL b2b_miso1: got %h want 0000", rx1); end
    n_cmp++; if (rx2 !== 16'hBEEF) begin n_bad++; $display("FAIL b2b_miso2: got %h want beef", rx2); end
    n_cmp++; if (data_out !== 16'h5678) begin n_bad++; $display("FAIL b2b_data_out: got %h want 5678", data_out); end
    n_cmp++; if (done_cnt !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL b2b_tx_empty: got %b want 1", tx_empty); end
    cpu_read();
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_partial_frame();
    logic [W-1:0] rx;
    done_cnt = 0;
    cs_low();
    spi_bits(16'hABCD, 9, rx);
    cs_high();
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL part_done_count: got %0d want 0", done_cnt); end
    n_cmp++; if (data_out !== 16'h5678) begin n_bad++; $display("FAIL part_data_out: got %h want 5678", data_out); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL part_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL part_idle: got miso_oe=%b want 0", miso_oe); end
    cs_low();
    spi_bits(16'h00FF, W, rx);
    cs_high();
    n_cmp++; if (data_out !== 16'h00FF) begin n_bad++; $display("FAIL part_next_data_out: got %h want 00ff", data_out); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL part_next_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (rx !== 16'h0000) begin n_bad++; $display("FAIL part_next_miso: got %h want 0000", rx); end
    cpu_read();
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] rx;
    cs_low();
    // Leave a pending TX word so reset must clear tx_full as well.
    cpu_write(16'h1111);
    spi_bits(16'h9999, 7, rx);
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    clks(3);
    rst = 1'b0;
    clks(4);
    n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL rstmid_miso_oe: got %b want 0", miso_oe); end
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL rstmid_miso: got %b want 0", miso); end
    n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL rstmid_data_out: got %h want 0000", data_out); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx_empty: got %b want 1", tx_empty); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
    done_cnt = 0;
    cs_low();
    spi_bits(16'hC3C3, W, rx);
    cs_high();
    n_cmp++; if (data_out !== 16'hC3C3) begin n_bad++; $display("FAIL rstmid_next_data_out: got %h want c3c3", data_out); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rstmid_next_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx !== 16'h0000) begin n_bad++; $display("FAIL rstmid_next_miso: got %h want 0000", rx); end
  endtask

  initial begin
    rst     = 1'b1;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    data_in = '0;
    we      = 1'b0;
    rd      = 1'b0;

    test_reset();
    test_single_word();
    test_no_tx();
    test_back_to_back();
    test_partial_frame();
    test_reset_mid_word();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_basic_spi_slave
